// File: rtl/rf_pkg.sv
// Shared defaults and types for the multi-port register file.
// The parameterised blocks derive their own address width with rf_aw().
package rf_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;

    function automatic int rf_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int RF_AW = rf_aw(RF_NREGS);

    typedef logic [RF_AW-1:0]   rf_addr_t;
    typedef logic [RF_XLEN-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: busy_set marks a register, any write clears it,
// and a set wins over a clear that lands on the same register in the same cycle.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS    = RF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_aw(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NWR-1:0]           we,
    input  logic [NWR-1:0][AW-1:0]   waddr,
    input  logic                     busy_set,
    input  logic [AW-1:0]            busy_addr,
    input  logic [NRD-1:0][AW-1:0]   raddr,
    output logic [NREGS-1:0]         busy_vec,
    output logic [NRD-1:0]           rd_busy
);

    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
        logic clr_hit;
        logic set_hit;

        always_comb begin
            clr_hit = 1'b0;
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && (waddr[i] == AW'(gi))) begin
                    clr_hit = 1'b1;
                end
            end
        end

        assign set_hit = busy_set && (busy_addr == AW'(gi)) && !((ZERO_REG != 0) && (gi == 0));
        assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // Lookup for the read ports; the top registers these alongside rdata.
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic b;

        always_comb begin
            b = (BYPASS != 0) ? busy_next[raddr[gi]] : busy_reg[raddr[gi]];
            if ((ZERO_REG != 0) && (raddr[gi] == '0)) begin
                b = 1'b0;
            end
        end

        assign rd_busy[gi] = b;
    end

    assign busy_vec = busy_reg;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with registered reads, optional write-to-read bypass,
// optional hardwired zero register and an attached busy-bit scoreboard.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = RF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_aw(NREGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NRD-1:0][AW-1:0]     raddr,
    output logic [NRD-1:0][XLEN-1:0]   rdata,
    output logic [NRD-1:0]             rbusy,
    input  logic [NWR-1:0]             we,
    input  logic [NWR-1:0][AW-1:0]     waddr,
    input  logic [NWR-1:0][XLEN-1:0]   wdata,
    input  logic                       busy_set,
    input  logic [AW-1:0]              busy_addr,
    output logic [NREGS-1:0]           busy_vec
);

    logic [XLEN-1:0]           regs_reg [NREGS];
    logic [NREGS-1:0]          wr_hit;
    logic [XLEN-1:0]           wr_val   [NREGS];
    logic [NRD-1:0][XLEN-1:0]  rdata_reg;
    logic [NRD-1:0][XLEN-1:0]  rdata_next;
    logic [NRD-1:0]            rbusy_reg;
    logic [NRD-1:0]            rd_busy;

    // Per-register write resolution: later ports overwrite earlier ones,
    // so the highest-index port targeting a register wins.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_wr
        logic            hit;
        logic [XLEN-1:0] val;

        always_comb begin
            hit = 1'b0;
            val = '0;
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && (waddr[i] == AW'(gi))) begin
                    hit = 1'b1;
                    val = wdata[i];
                end
            end
            if ((ZERO_REG != 0) && (gi == 0)) begin
                hit = 1'b0;
            end
        end

        assign wr_hit[gi] = hit;
        assign wr_val[gi] = val;
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [XLEN-1:0] d;

        always_comb begin
            d = regs_reg[raddr[gi]];
            if ((BYPASS != 0) && wr_hit[raddr[gi]]) begin
                d = wr_val[raddr[gi]];
            end
            if ((ZERO_REG != 0) && (raddr[gi] == '0)) begin
                d = '0;
            end
        end

        assign rdata_next[gi] = d;
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .raddr     (raddr),
        .busy_vec  (busy_vec),
        .rd_busy   (rd_busy)
    );

    // Reset clears the array outright, which is why it lives in flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_reg[r] <= '0;
            end
            rdata_reg <= '0;
            rbusy_reg <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wr_hit[r]) begin
                    regs_reg[r] <= wr_val[r];
                end
            end
            rdata_reg <= rdata_next;
            rbusy_reg <= rd_busy;
        end
    end

    assign rdata = rdata_reg;
    assign rbusy = rbusy_reg;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypassing and a non-bypassing instance share stimulus;
// directed feature tasks plus a randomised run checked against a queued reference model.
module tb_reg_file_mp;
    import rf_pkg::*;

    localparam int NRD   = 4;
    localparam int NWR   = 2;
    localparam int NREGS = RF_NREGS;
    localparam int XLEN  = RF_XLEN;
    localparam int AW    = RF_AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset;
    logic [NRD-1:0][AW-1:0]    raddr;
    logic [NWR-1:0]            we;
    logic [NWR-1:0][AW-1:0]    waddr;
    logic [NWR-1:0][XLEN-1:0]  wdata;
    logic                      busy_set;
    logic [AW-1:0]             busy_addr;

    logic [NRD-1:0][XLEN-1:0]  rdata_b, rdata_n;
    logic [NRD-1:0]            rbusy_b, rbusy_n;
    logic [NREGS-1:0]          busy_vec_b, busy_vec_n;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .we(we), .waddr(waddr), .wdata(wdata), .busy_set(busy_set), .busy_addr(busy_addr),
        .busy_vec(busy_vec_b)
    );

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1)) dut_n (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .we(we), .waddr(waddr), .wdata(wdata), .busy_set(busy_set), .busy_addr(busy_addr),
        .busy_vec(busy_vec_n)
    );

    typedef struct {
        logic [NRD-1:0][XLEN-1:0] rd_b;
        logic [NRD-1:0][XLEN-1:0] rd_n;
        logic [NRD-1:0]           rb_b;
        logic [NRD-1:0]           rb_n;
        logic [NREGS-1:0]         bv;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             e;
    rf_data_t         m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    int               errors = 0;
    int               checks = 0;
    int               txn    = 0;

    // Reference model: pushes the outputs expected after the coming edge, then advances.
    task automatic predict();
        exp_t             x;
        logic [NREGS-1:0] hit, clr, bnext;
        rf_data_t         val [NREGS];
        int               a;
        if (reset) begin
            x.rd_b = '0; x.rd_n = '0; x.rb_b = '0; x.rb_n = '0; x.bv = '0;
            exp_q.push_back(x);
            for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
            m_busy = '0;
            return;
        end
        for (int r = 0; r < NREGS; r++) begin
            hit[r] = 1'b0; clr[r] = 1'b0; val[r] = '0;
            for (int i = 0; i < NWR; i++) begin
                if (we[i] && int'(waddr[i]) == r) begin
                    hit[r] = 1'b1; clr[r] = 1'b1; val[r] = wdata[i];
                end
            end
            if (r == 0) hit[r] = 1'b0;
            bnext[r] = (r != 0 && busy_set && int'(busy_addr) == r) || (m_busy[r] && !clr[r]);
        end
        for (int j = 0; j < NRD; j++) begin
            a = int'(raddr[j]);
            x.rd_b[j] = (a == 0) ? '0 : (hit[a] ? val[a] : m_regs[a]);
            x.rd_n[j] = (a == 0) ? '0 : m_regs[a];
            x.rb_b[j] = (a == 0) ? 1'b0 : bnext[a];
            x.rb_n[j] = (a == 0) ? 1'b0 : m_busy[a];
        end
        x.bv = bnext;
        exp_q.push_back(x);
        for (int r = 0; r < NREGS; r++) if (hit[r]) m_regs[r] = val[r];
        m_busy = bnext;
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d rst=%0b we=%b wa=%h/%h bs=%0b ba=%0d ra=%h rd0_b=%h rd0_n=%h bv=%h",
                 txn, reset, we, waddr[1], waddr[0], busy_set, busy_addr, raddr, rdata_b[0], rdata_n[0], busy_vec_b);
    endtask

    task automatic idle();
        reset = 1'b0; we = '0; busy_set = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; we = '0; waddr = '0; wdata = '0; busy_set = 1'b0; busy_addr = '0; raddr = '0;
        step();
        checks++; if (rdata_b !== '0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata_b); end
        checks++; if (busy_vec_b !== '0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy_vec_b); end
        idle(); we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'hDEAD_BEEF; busy_set = 1'b1; busy_addr = 5'd5; raddr[0] = 5'd5;
        step();
        checks++; if (rdata_b[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pre_reset_write got %h exp deadbeef", rdata_b[0]); end
        reset = 1'b1; we = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'h1234; busy_set = 1'b0;
        step();
        checks++; if (busy_vec_b !== '0) begin errors++; $display("FAIL reset_clears_busy got %h exp 0", busy_vec_b); end
        idle(); raddr[0] = 5'd5;
        step();
        checks++; if (rdata_b[0] !== '0) begin errors++; $display("FAIL post_reset_read_b got %h exp 0", rdata_b[0]); end
        checks++; if (rdata_n[0] !== '0) begin errors++; $display("FAIL post_reset_read_n got %h exp 0", rdata_n[0]); end
    endtask

    task automatic test_bypass();
        idle(); we = 2'b01; waddr[0] = 5'd1; wdata[0] = 32'd10; raddr[0] = 5'd1;
        step();
        checks++; if (rdata_b[0] !== 32'd10) begin errors++; $display("FAIL bypass_on got %h exp a", rdata_b[0]); end
        checks++; if (rdata_n[0] !== 32'd0) begin errors++; $display("FAIL bypass_off_first got %h exp 0", rdata_n[0]); end
        idle();
        step();
        checks++; if (rdata_n[0] !== 32'd10) begin errors++; $display("FAIL bypass_off_next got %h exp a", rdata_n[0]); end
    endtask

    task automatic test_zero_reg();
        idle(); we = 2'b01; waddr[0] = 5'd0; wdata[0] = 32'd10; busy_set = 1'b1; busy_addr = 5'd0; raddr[0] = 5'd0;
        step();
        checks++; if (rdata_b[0] !== 32'd0) begin errors++; $display("FAIL zero_rdata_b got %h exp 0", rdata_b[0]); end
        checks++; if (busy_vec_b[0] !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", busy_vec_b[0]); end
        checks++; if (rbusy_b[0] !== 1'b0) begin errors++; $display("FAIL zero_rbusy got %b exp 0", rbusy_b[0]); end
        idle();
        step();
        checks++; if (rdata_n[0] !== 32'd0) begin errors++; $display("FAIL zero_rdata_n got %h exp 0", rdata_n[0]); end
    endtask

    task automatic test_conflict();
        idle(); we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7; wdata[0] = 32'h11; wdata[1] = 32'h22; raddr[0] = 5'd7;
        step();
        checks++; if (rdata_b[0] !== 32'h22) begin errors++; $display("FAIL conflict_bypass got %h exp 22", rdata_b[0]); end
        idle();
        step();
        checks++; if (rdata_n[0] !== 32'h22) begin errors++; $display("FAIL conflict_stored got %h exp 22", rdata_n[0]); end
    endtask

    task automatic test_scoreboard();
        idle(); busy_set = 1'b1; busy_addr = 5'd3; raddr[0] = 5'd3;
        step();
        checks++; if (busy_vec_b[3] !== 1'b1) begin errors++; $display("FAIL sb_set got %b exp 1", busy_vec_b[3]); end
        checks++; if (rbusy_b[0] !== 1'b1) begin errors++; $display("FAIL sb_rbusy_b got %b exp 1", rbusy_b[0]); end
        checks++; if (rbusy_n[0] !== 1'b0) begin errors++; $display("FAIL sb_rbusy_n_pre got %b exp 0", rbusy_n[0]); end
        idle();
        step();
        checks++; if (rbusy_n[0] !== 1'b1) begin errors++; $display("FAIL sb_rbusy_n_post got %b exp 1", rbusy_n[0]); end
        idle(); we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'h33;
        step();
        checks++; if (busy_vec_b[3] !== 1'b0) begin errors++; $display("FAIL sb_clear got %b exp 0", busy_vec_b[3]); end
        checks++; if (rbusy_b[0] !== 1'b0) begin errors++; $display("FAIL sb_clear_rbusy got %b exp 0", rbusy_b[0]); end
        idle(); we = 2'b10; waddr[1] = 5'd3; wdata[1] = 32'h44; busy_set = 1'b1; busy_addr = 5'd3;
        step();
        checks++; if (busy_vec_b[3] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b exp 1", busy_vec_b[3]); end
        checks++; if (busy_vec_n[3] !== 1'b1) begin errors++; $display("FAIL sb_set_wins_n got %b exp 1", busy_vec_n[3]); end
    endtask

    task automatic test_all_ports();
        idle(); we = 2'b11; waddr[0] = 5'd1; wdata[0] = 32'd1; waddr[1] = 5'd2; wdata[1] = 32'd2;
        step();
        idle(); we = 2'b11; waddr[0] = 5'd3; wdata[0] = 32'd3; waddr[1] = 5'd4; wdata[1] = 32'd4;
        step();
        idle();
        for (int j = 0; j < NRD; j++) raddr[j] = AW'(j + 1);
        step();
        for (int j = 0; j < NRD; j++) begin
            checks++;
            if (rdata_b[j] !== 32'(j + 1) || rdata_n[j] !== 32'(j + 1)) begin
                errors++; $display("FAIL all_ports[%0d] got %h/%h exp %h", j, rdata_b[j], rdata_n[j], j + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            reset     = ($urandom_range(39) == 0);
            we        = NWR'($urandom);
            busy_set  = $urandom_range(1);
            busy_addr = AW'($urandom);
            for (int i = 0; i < NWR; i++) begin
                waddr[i] = AW'($urandom_range(7));
                wdata[i] = $urandom;
            end
            for (int j = 0; j < NRD; j++) raddr[j] = AW'($urandom_range(7));
            step();
            checks++; if (rdata_b !== e.rd_b) begin errors++; $display("FAIL rand_rdata_b got %h exp %h", rdata_b, e.rd_b); end
            checks++; if (rdata_n !== e.rd_n) begin errors++; $display("FAIL rand_rdata_n got %h exp %h", rdata_n, e.rd_n); end
            checks++; if (rbusy_b !== e.rb_b) begin errors++; $display("FAIL rand_rbusy_b got %b exp %b", rbusy_b, e.rb_b); end
            checks++; if (rbusy_n !== e.rb_n) begin errors++; $display("FAIL rand_rbusy_n got %b exp %b", rbusy_n, e.rb_n); end
            checks++; if (busy_vec_b !== e.bv || busy_vec_n !== e.bv) begin
                errors++; $display("FAIL rand_busy_vec got %h/%h exp %h", busy_vec_b, busy_vec_n, e.bv);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_busy = '0;
        for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_conflict();
        test_scoreboard();
        test_all_ports();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
